// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS LSUs. Idle channels
// grant requesters round-robin, forward the access to memory and relay the
// completion back to the requester.
// Build option: define MEM_ARB_WRITE_EN to include the write path. Without it
// the block is a read-only arbiter and all write outputs are tied to zero.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int IDW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

`ifdef MEM_ARB_WRITE_EN
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_READ_WAIT   = 3'd1,
    ST_WRITE_WAIT  = 3'd2,
    ST_READ_RELAY  = 3'd3,
    ST_WRITE_RELAY = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_READ_RELAY = 2'd2
  } state_e;
`endif

  // Unpacked views of the flat buses
  logic [ADDR_BITS-1:0]     cons_rd_addr_s [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     mem_rd_data_s  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] cons_wr_valid_s;

  // Channel state
  state_e                   state_q        [NUM_CHANNELS];
  state_e                   state_d        [NUM_CHANNELS];
  logic [IDW-1:0]           id_q           [NUM_CHANNELS];
  logic [IDW-1:0]           id_d           [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claim_q, claim_d;
  logic [IDW-1:0]           rr_q, rr_d;

  // Registered read outputs
  logic [NUM_CHANNELS-1:0]  mem_rd_valid_q, mem_rd_valid_d;
  logic [ADDR_BITS-1:0]     mem_rd_addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     mem_rd_addr_d  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] cons_rd_ready_q, cons_rd_ready_d;
  logic [DATA_BITS-1:0]     cons_rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     cons_rd_data_d [NUM_CONSUMERS];

  // Grant search results
  logic [NUM_CHANNELS-1:0]  grant_s;
  logic [NUM_CHANNELS-1:0]  grant_rd_s;
  logic [IDW-1:0]           grant_id_s     [NUM_CHANNELS];

`ifdef MEM_ARB_WRITE_EN
  logic [ADDR_BITS-1:0]     cons_wr_addr_s [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     cons_wr_data_s [NUM_CONSUMERS];
  logic [NUM_CHANNELS-1:0]  mem_wr_valid_q, mem_wr_valid_d;
  logic [ADDR_BITS-1:0]     mem_wr_addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     mem_wr_addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     mem_wr_data_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     mem_wr_data_d  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] cons_wr_ready_q, cons_wr_ready_d;

  assign cons_wr_valid_s      = consumer_write_valid;
  assign mem_write_valid      = mem_wr_valid_q;
  assign consumer_write_ready = cons_wr_ready_q;
`else
  // Write inputs are intentionally ignored in the read-only build
  logic unused_write_s;
  assign unused_write_s = ^{consumer_write_valid, consumer_write_address,
                            consumer_write_data, mem_write_ready};

  assign cons_wr_valid_s      = '0;
  assign mem_write_valid      = '0;
  assign mem_write_address    = '0;
  assign mem_write_data       = '0;
  assign consumer_write_ready = '0;
`endif

  assign mem_read_valid      = mem_rd_valid_q;
  assign consumer_read_ready = cons_rd_ready_q;

  for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_cons
    assign cons_rd_addr_s[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
    assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = cons_rd_data_q[i];
`ifdef MEM_ARB_WRITE_EN
    assign cons_wr_addr_s[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
    assign cons_wr_data_s[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
`endif
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign mem_rd_data_s[c] = mem_read_data[c*DATA_BITS +: DATA_BITS];
    assign mem_read_address[c*ADDR_BITS +: ADDR_BITS] = mem_rd_addr_q[c];
`ifdef MEM_ARB_WRITE_EN
    assign mem_write_address[c*ADDR_BITS +: ADDR_BITS] = mem_wr_addr_q[c];
    assign mem_write_data[c*DATA_BITS +: DATA_BITS]    = mem_wr_data_q[c];
`endif
  end

  // Grant search: idle channels in index order take the first unclaimed requester from rr
  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken_v;
    logic [IDW-1:0]           idx_v;
    logic                     found_v;
    taken_v    = claim_q;
    idx_v      = '0;
    found_v    = 1'b0;
    rr_d       = rr_q;
    grant_s    = '0;
    grant_rd_s = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_id_s[c] = '0;
      found_v       = 1'b0;
      if (state_q[c] == ST_IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx_v = IDW'((int'(rr_q) + k) % NUM_CONSUMERS);
          if (!found_v && !taken_v[idx_v] &&
              (consumer_read_valid[idx_v] || cons_wr_valid_s[idx_v])) begin
            // Granted consumers are marked taken so later channels skip them
            found_v        = 1'b1;
            taken_v[idx_v] = 1'b1;
            grant_s[c]     = 1'b1;
            grant_rd_s[c]  = consumer_read_valid[idx_v];
            grant_id_s[c]  = idx_v;
            rr_d           = IDW'((int'(idx_v) + 1) % NUM_CONSUMERS);
          end else begin
            found_v = found_v;
          end
        end
      end else begin
        grant_s[c] = 1'b0;
      end
    end
  end

  // Channel FSMs: next state and next registered outputs
  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    claim_d         = claim_q;
    mem_rd_valid_d  = mem_rd_valid_q;
    mem_rd_addr_d   = mem_rd_addr_q;
    cons_rd_ready_d = cons_rd_ready_q;
    cons_rd_data_d  = cons_rd_data_q;
`ifdef MEM_ARB_WRITE_EN
    mem_wr_valid_d  = mem_wr_valid_q;
    mem_wr_addr_d   = mem_wr_addr_q;
    mem_wr_data_d   = mem_wr_data_q;
    cons_wr_ready_d = cons_wr_ready_q;
`endif
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        ST_IDLE: begin
          if (grant_s[c]) begin
            id_d[c]                = grant_id_s[c];
            claim_d[grant_id_s[c]] = 1'b1;
            if (grant_rd_s[c]) begin
              state_d[c]        = ST_READ_WAIT;
              mem_rd_valid_d[c] = 1'b1;
              mem_rd_addr_d[c]  = cons_rd_addr_s[grant_id_s[c]];
            end else begin
`ifdef MEM_ARB_WRITE_EN
              state_d[c]        = ST_WRITE_WAIT;
              mem_wr_valid_d[c] = 1'b1;
              mem_wr_addr_d[c]  = cons_wr_addr_s[grant_id_s[c]];
              mem_wr_data_d[c]  = cons_wr_data_s[grant_id_s[c]];
`else
              state_d[c]        = ST_IDLE;
`endif
            end
          end else begin
            state_d[c] = ST_IDLE;
          end
        end
        ST_READ_WAIT: begin
          if (mem_read_ready[c]) begin
            mem_rd_valid_d[c]        = 1'b0;
            cons_rd_data_d[id_q[c]]  = mem_rd_data_s[c];
            cons_rd_ready_d[id_q[c]] = 1'b1;
            state_d[c]               = ST_READ_RELAY;
          end else begin
            mem_rd_valid_d[c] = 1'b1;
          end
        end
        ST_READ_RELAY: begin
          if (!consumer_read_valid[id_q[c]]) begin
            cons_rd_ready_d[id_q[c]] = 1'b0;
            claim_d[id_q[c]]         = 1'b0;
            state_d[c]               = ST_IDLE;
          end else begin
            cons_rd_ready_d[id_q[c]] = 1'b1;
          end
        end
`ifdef MEM_ARB_WRITE_EN
        ST_WRITE_WAIT: begin
          if (mem_write_ready[c]) begin
            mem_wr_valid_d[c]        = 1'b0;
            cons_wr_ready_d[id_q[c]] = 1'b1;
            state_d[c]               = ST_WRITE_RELAY;
          end else begin
            mem_wr_valid_d[c] = 1'b1;
          end
        end
        ST_WRITE_RELAY: begin
          if (!consumer_write_valid[id_q[c]]) begin
            cons_wr_ready_d[id_q[c]] = 1'b0;
            claim_d[id_q[c]]         = 1'b0;
            state_d[c]               = ST_IDLE;
          end else begin
            cons_wr_ready_d[id_q[c]] = 1'b1;
          end
        end
`endif
        default: begin
          state_d[c] = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c]       <= ST_IDLE;
        id_q[c]          <= '0;
        mem_rd_addr_q[c] <= '0;
`ifdef MEM_ARB_WRITE_EN
        mem_wr_addr_q[c] <= '0;
        mem_wr_data_q[c] <= '0;
`endif
      end
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        cons_rd_data_q[i] <= '0;
      end
      claim_q         <= '0;
      rr_q            <= '0;
      mem_rd_valid_q  <= '0;
      cons_rd_ready_q <= '0;
`ifdef MEM_ARB_WRITE_EN
      mem_wr_valid_q  <= '0;
      cons_wr_ready_q <= '0;
`endif
    end else begin
      state_q         <= state_d;
      id_q            <= id_d;
      claim_q         <= claim_d;
      rr_q            <= rr_d;
      mem_rd_valid_q  <= mem_rd_valid_d;
      mem_rd_addr_q   <= mem_rd_addr_d;
      cons_rd_ready_q <= cons_rd_ready_d;
      cons_rd_data_q  <= cons_rd_data_d;
`ifdef MEM_ARB_WRITE_EN
      mem_wr_valid_q  <= mem_wr_valid_d;
      mem_wr_addr_q   <= mem_wr_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      cons_wr_ready_q <= cons_wr_ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: a 1-channel and a 2-channel instance
// (4 consumers, 8-bit address/data) driven by a linear sequence of steps.
module tb_lsu_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   who;

  // Instance 1: 4 consumers, 1 channel
  logic [3:0]  c1_rv, c1_rr, c1_wv, c1_wr;
  logic [31:0] c1_ra, c1_rd, c1_wa, c1_wd;
  logic [0:0]  c1_mrv, c1_mrr, c1_mwv, c1_mwr;
  logic [7:0]  c1_mra, c1_mrd, c1_mwa, c1_mwd;

  // Instance 2: 4 consumers, 2 channels
  logic [3:0]  c2_rv, c2_rr, c2_wv, c2_wr;
  logic [31:0] c2_ra, c2_rd, c2_wa, c2_wd;
  logic [1:0]  c2_mrv, c2_mrr, c2_mwv, c2_mwr;
  logic [15:0] c2_mra, c2_mrd, c2_mwa, c2_mwd;

  lsu_mem_arbiter #(
    .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(8)
  ) dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c1_rv), .consumer_read_address(c1_ra),
    .consumer_read_ready(c1_rr), .consumer_read_data(c1_rd),
    .consumer_write_valid(c1_wv), .consumer_write_address(c1_wa),
    .consumer_write_data(c1_wd), .consumer_write_ready(c1_wr),
    .mem_read_valid(c1_mrv), .mem_read_address(c1_mra),
    .mem_read_ready(c1_mrr), .mem_read_data(c1_mrd),
    .mem_write_valid(c1_mwv), .mem_write_address(c1_mwa),
    .mem_write_data(c1_mwd), .mem_write_ready(c1_mwr)
  );

  lsu_mem_arbiter #(
    .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(8)
  ) dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c2_rv), .consumer_read_address(c2_ra),
    .consumer_read_ready(c2_rr), .consumer_read_data(c2_rd),
    .consumer_write_valid(c2_wv), .consumer_write_address(c2_wa),
    .consumer_write_data(c2_wd), .consumer_write_ready(c2_wr),
    .mem_read_valid(c2_mrv), .mem_read_address(c2_mra),
    .mem_read_ready(c2_mrr), .mem_read_data(c2_mrd),
    .mem_write_valid(c2_mwv), .mem_write_address(c2_mwa),
    .mem_write_data(c2_mwd), .mem_write_ready(c2_mwr)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serve one read on instance 1; consumer i uses address 0x20+i, data 0x50+i
  task automatic serve1(output int id);
    int n;
    n = 0;
    while (c1_mrv !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("serve_wait", 32'(n < 20), 32'd1);
    id = int'(c1_mra) - 32;
    check("serve_id_range", 32'(id >= 0 && id <= 3), 32'd1);
    if (id < 0 || id > 3) id = 0;
    c1_mrr = 1'b1;
    c1_mrd = 8'h50 + 8'(id);
    tick();
    c1_mrr = 1'b0;
    c1_mrd = 8'h00;
    check("serve_ready", 32'(c1_rr), 32'(4'b0001 << id));
    check("serve_data", 32'(c1_rd[id*8 +: 8]), 32'(8'h50 + 8'(id)));
    check("serve_mrv_drop", 32'(c1_mrv), 32'd0);
    c1_rv[id] = 1'b0;
    tick();
    check("serve_release", 32'(c1_rr), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    c1_rv = 4'h0; c1_ra = {8'h23, 8'h22, 8'h21, 8'h20};
    c1_wv = 4'h0; c1_wa = 32'h0; c1_wd = 32'h0;
    c1_mrr = 1'b0; c1_mrd = 8'h00; c1_mwr = 1'b0;
    c2_rv = 4'h0; c2_ra = {8'h33, 8'h32, 8'h31, 8'h30};
    c2_wv = 4'h0; c2_wa = 32'h0; c2_wd = 32'h0;
    c2_mrr = 2'b00; c2_mrd = 16'h0000; c2_mwr = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_mrv", 32'(c1_mrv), 32'd0);
    check("rst_mra", 32'(c1_mra), 32'd0);
    check("rst_mwv", 32'(c1_mwv), 32'd0);
    check("rst_mwa", 32'(c1_mwa), 32'd0);
    check("rst_mwd", 32'(c1_mwd), 32'd0);
    check("rst_crr", 32'(c1_rr), 32'd0);
    check("rst_crd", c1_rd, 32'd0);
    check("rst_cwr", 32'(c1_wr), 32'd0);
    check("rst_mrv2", 32'(c2_mrv), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_mrv", 32'(c1_mrv), 32'd0);

    // Round robin: all four request; consumer 0 re-requests after its turn
    c1_rv = 4'hF;
    serve1(who); check("rr_order0", who, 32'd0);
    c1_rv[0] = 1'b1;
    serve1(who); check("rr_order1", who, 32'd1);
    serve1(who); check("rr_order2", who, 32'd2);
    serve1(who); check("rr_order3", who, 32'd3);
    serve1(who); check("rr_order4", who, 32'd0);

    // Single read: consumer 1, addr 0x10, memory answers 0xA5 after 3 cycles
    c1_ra[15:8] = 8'h10;
    c1_rv = 4'b0010;
    tick();
    check("rd_mrv", 32'(c1_mrv), 32'd1);
    check("rd_addr", 32'(c1_mra), 32'h10);
    tick();
    tick();
    check("rd_hold", 32'(c1_mrv), 32'd1);
    check("rd_no_ready_yet", 32'(c1_rr), 32'd0);
    c1_mrr = 1'b1; c1_mrd = 8'hA5;
    tick();
    c1_mrr = 1'b0; c1_mrd = 8'h00;
    check("rd_ready", 32'(c1_rr), 32'b0010);
    check("rd_data", 32'(c1_rd[15:8]), 32'hA5);
    check("rd_mrv_drop", 32'(c1_mrv), 32'd0);
    tick();
    check("rd_ready_held", 32'(c1_rr), 32'b0010);
    c1_rv = 4'h0;
    tick();
    check("rd_ready_drop", 32'(c1_rr), 32'd0);
    check("rd_data_hold", 32'(c1_rd[15:8]), 32'hA5);
    c1_ra[15:8] = 8'h21;

    // Two channels: memory ready while idle is ignored
    c2_mrr = 2'b11; c2_mrd = 16'hEEEE;
    tick();
    c2_mrr = 2'b00; c2_mrd = 16'h0000;
    check("ign_ready", 32'(c2_rr), 32'd0);
    check("ign_data", c2_rd, 32'd0);
    check("ign_mrv", 32'(c2_mrv), 32'd0);

    // Consumers 0 and 3 together: one per channel in the same cycle
    c2_rv = 4'b1001;
    tick();
    check("2ch_mrv", 32'(c2_mrv), 32'b11);
    check("2ch_addr0", 32'(c2_mra[7:0]), 32'h30);
    check("2ch_addr1", 32'(c2_mra[15:8]), 32'h33);
    c2_mrr = 2'b11; c2_mrd = {8'h22, 8'h11};
    tick();
    c2_mrr = 2'b00; c2_mrd = 16'h0000;
    check("2ch_ready", 32'(c2_rr), 32'b1001);
    check("2ch_data0", 32'(c2_rd[7:0]), 32'h11);
    check("2ch_data3", 32'(c2_rd[31:24]), 32'h22);
    check("2ch_mrv_drop", 32'(c2_mrv), 32'd0);
    tick();
    check("2ch_no_regrant", 32'(c2_mrv), 32'd0);
    c2_rv = 4'h0;
    tick();
    check("2ch_release", 32'(c2_rr), 32'd0);

    // Lone requester on two channels uses channel 0 only
    c2_rv = 4'b0010;
    tick();
    check("1req_mrv", 32'(c2_mrv), 32'b01);
    check("1req_addr", 32'(c2_mra[7:0]), 32'h31);
    c2_mrr = 2'b01; c2_mrd = 16'h0044;
    tick();
    c2_mrr = 2'b00; c2_mrd = 16'h0000;
    check("1req_ready", 32'(c2_rr), 32'b0010);
    check("1req_data", 32'(c2_rd[15:8]), 32'h44);
    c2_rv = 4'h0;
    tick();
    check("1req_release", 32'(c2_rr), 32'd0);

    // Reset in the middle of a read, then the held request is re-granted
    c1_rv = 4'b0100;
    tick();
    check("mid_mrv", 32'(c1_mrv), 32'd1);
    check("mid_addr", 32'(c1_mra), 32'h22);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_mrv", 32'(c1_mrv), 32'd0);
    check("mid_rst_mra", 32'(c1_mra), 32'd0);
    check("mid_rst_crd", c1_rd, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("mid_rst_hold", 32'(c1_mrv), 32'd0);
    tick();
    check("post_rst_mrv", 32'(c1_mrv), 32'd1);
    check("post_rst_addr", 32'(c1_mra), 32'h22);
    serve1(who); check("post_rst_id", who, 32'd2);

`ifdef MEM_ARB_WRITE_EN
    // Write: consumer 2 stores 0x3C at 0x7F
    c1_wv = 4'b0100;
    c1_wa[23:16] = 8'h7F;
    c1_wd[23:16] = 8'h3C;
    tick();
    check("wr_mwv", 32'(c1_mwv), 32'd1);
    check("wr_addr", 32'(c1_mwa), 32'h7F);
    check("wr_data", 32'(c1_mwd), 32'h3C);
    check("wr_no_read", 32'(c1_mrv), 32'd0);
    tick();
    check("wr_hold", 32'(c1_mwv), 32'd1);
    c1_mwr = 1'b1;
    tick();
    c1_mwr = 1'b0;
    check("wr_mwv_drop", 32'(c1_mwv), 32'd0);
    check("wr_ready", 32'(c1_wr), 32'b0100);
    tick();
    check("wr_ready_held", 32'(c1_wr), 32'b0100);
    c1_wv = 4'h0;
    tick();
    check("wr_release", 32'(c1_wr), 32'd0);
`else
    // Read-only build: write requests are never served, reads still are
    c1_wv = 4'b0001;
    c1_wa[7:0] = 8'h40;
    c1_wd[7:0] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nowr_mwv", 32'(c1_mwv), 32'd0);
      check("nowr_cwr", 32'(c1_wr), 32'd0);
    end
    check("nowr_mrv", 32'(c1_mrv), 32'd0);
    c1_rv = 4'b0001;
    serve1(who); check("nowr_read_id", who, 32'd0);
    check("nowr_mwv_end", 32'(c1_mwv), 32'd0);
    check("nowr_mwa_end", 32'(c1_mwa), 32'd0);
    check("nowr_cwr_end", 32'(c1_wr), 32'd0);
    c1_wv = 4'h0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
Shares NUM_CHANNELS memory channels among NUM_CONSUMERS per-thread LSUs of a core.
- Accepts LSU read/write requests on valid/ready handshakes.
- Grants them round-robin to free channels, forwards each to external memory and relays the response back.
- Sits between the LSU array and the data-memory port of the core.

Parameters:
NUM_CONSUMERS, 4, number of LSU requesters (>=1)
NUM_CHANNELS, 1, number of concurrent memory channels (1..NUM_CONSUMERS)
ADDR_BITS, 8, address width
DATA_BITS, 8, data width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  per-LSU read address
consumer_read_ready  out  NUM_CONSUMERS  per-LSU read completion
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  per-LSU read data
consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  per-LSU write address
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  per-LSU write data
consumer_write_ready  out  NUM_CONSUMERS  per-LSU write completion
mem_read_valid  out  NUM_CHANNELS  per-channel read request
mem_read_address  out  NUM_CHANNELS*ADDR_BITS  per-channel read address
mem_read_ready  in  NUM_CHANNELS  per-channel read done
mem_read_data  in  NUM_CHANNELS*DATA_BITS  per-channel read data
mem_write_valid  out  NUM_CHANNELS  per-channel write request
mem_write_address  out  NUM_CHANNELS*ADDR_BITS  per-channel write address
mem_write_data  out  NUM_CHANNELS*DATA_BITS  per-channel write data
mem_write_ready  in  NUM_CHANNELS  per-channel write done

Behaviour:
- Reset (reset==0, async):
  - All outputs 0.
  - All channels IDLE.
  - Claim mask cleared.
  - Round-robin pointer rr = 0.
  - Reset mid-transaction abandons it; the memory sees valid drop.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE, grant search:
  - Scan consumers starting at rr, wrapping mod NUM_CONSUMERS.
  - Take the first consumer that has read_valid or write_valid and is not claimed.
  - If both valids are set, read wins.
  - On grant:
    - Set the claim bit.
    - Drive mem_*_valid=1 with the address (and data for a write) on the next cycle.
    - Store the consumer id.
    - Go to READ_WAIT or WRITE_WAIT.
  - Grant-to-mem_valid latency is 1 cycle.
- Multiple channels in one cycle:
  - Channels are served in index order.
  - Each skips consumers already granted this cycle, so no consumer is ever granted twice.
- rr update: after any grant cycle, rr = (last granted id + 1) mod NUM_CONSUMERS. Otherwise rr is unchanged.
- READ_WAIT:
  - mem_read_valid is held until mem_read_ready==1.
  - Then mem_read_valid<=0, consumer_read_data[id]<=mem_read_data, consumer_read_ready[id]<=1, go to READ_RELAY.
- WRITE_WAIT: same as READ_WAIT using the write signals; no data returns. Go to WRITE_RELAY.
- *_RELAY:
  - consumer_*_ready[id] is held until the consumer drops its valid.
  - Then ready<=0, claim bit cleared, go to IDLE.
  - The channel may grant again on the cycle after it returns to IDLE.
- consumer_read_data[id] holds its value until overwritten by a later read for that consumer.
- Request held with no free channel: it waits indefinitely, with no timeout.
- NUM_CHANNELS==NUM_CONSUMERS: every requester is granted in the same cycle.
- Memory ready asserted while the channel is not in a WAIT state is ignored.

Optional Feature:
MEM_ARB_WRITE_EN
- Defined: full read/write behaviour as above.
- Undefined:
  - Write path removed; the block is a read-only arbiter (e.g. program memory).
  - consumer_write_valid is ignored.
  - consumer_write_ready, mem_write_valid, mem_write_address and mem_write_data are tied to 0.
  - WRITE_WAIT and WRITE_RELAY states are absent.

Test Plan:
- Reset: hold reset=0 mid-read, release -> all outputs 0, rr=0; next request from consumer 2 is granted to channel 0 after 1 cycle.
- Single read, 4 consumers, 1 channel: consumer 1 reads addr 0x10; mem returns ready with data 0xA5 after 3 cycles -> mem_read_address=0x10; consumer_read_data[1]=0xA5 with consumer_read_ready[1]=1; ready drops the cycle after valid drops.
- Round-robin: consumers 0-3 assert read_valid together, 1 channel, mem ready after 1 cycle -> grant order 0,1,2,3; with 1 fixed before 0 re-requests, order continues 1,2,3,0 (rr rotates).
- Two channels: consumers 0 and 3 request together -> channel 0 takes consumer 0, channel 1 takes consumer 3 in the same cycle; no double grant.
- Write (MEM_ARB_WRITE_EN defined): consumer 2 writes 0x3C to addr 0x7F -> mem_write_address=0x7F, mem_write_data=0x3C; consumer_write_ready[2]=1 after mem_write_ready.
- Write disabled (macro undefined): consumer 0 asserts write_valid -> mem_write_valid stays 0 and consumer_write_ready stays 0 indefinitely; reads still served.
